spi_cfg_ctrl: RTL and testbench



---
 rtl/spi_cfg_pkg.sv | 45 ++++
 rtl/spi_cfg_ctrl_sync_edge.sv | 28 ++
 rtl/spi_cfg_ctrl.sv | 125 ++++++++++++
 tb/tb_spi_cfg_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration controller: cfg_word field
// layout, power-on defaults and the frame FSM state encoding.
package spi_cfg_pkg;

    localparam int ACC_INC_LSB     = 0;
    localparam int ACC_INC_W       = 18;
    localparam int DF_INC_COEF_LSB = 18;
    localparam int DF_INC_COEF_W   = 4;
    localparam int DF_INC_FACT_LSB = 22;
    localparam int DF_INC_FACT_W   = 2;
    localparam int DAC_ENA_LSB     = 24;
    localparam int DAC_ENA_W       = 5;
    localparam int DITH_FACT_LSB   = 29;
    localparam int DITH_FACT_W     = 3;
    localparam int FLAGS_LSB       = 32;
    localparam int FLAGS_W         = 4;
    localparam int CFG_W           = 36;

    localparam logic [ACC_INC_W-1:0]     ACC_INC_DEF     = 18'd52429;
    localparam logic [DF_INC_COEF_W-1:0] DF_INC_COEF_DEF = 4'd12;
    localparam logic [DF_INC_FACT_W-1:0] DF_INC_FACT_DEF = 2'd0;
    localparam logic [DAC_ENA_W-1:0]     DAC_ENA_DEF     = 5'b11111;
    localparam logic [DITH_FACT_W-1:0]   DITH_FACT_DEF   = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        ABORT
    } state_t;

    // Assembles the reset value of cfg_word from the per-field defaults.
    function automatic logic [CFG_W-1:0] cfg_default();
        logic [CFG_W-1:0] w;
        w = '0;
        w[ACC_INC_LSB     +: ACC_INC_W]     = ACC_INC_DEF;
        w[DF_INC_COEF_LSB +: DF_INC_COEF_W] = DF_INC_COEF_DEF;
        w[DF_INC_FACT_LSB +: DF_INC_FACT_W] = DF_INC_FACT_DEF;
        w[DAC_ENA_LSB     +: DAC_ENA_W]     = DAC_ENA_DEF;
        w[DITH_FACT_LSB   +: DITH_FACT_W]   = DITH_FACT_DEF;
        w[FLAGS_LSB       +: FLAGS_W]       = '0;
        return w;
    endfunction

endpackage

// File: rtl/spi_cfg_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with a history flop
// providing single-cycle rise and fall strobes in the clk domain.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI slave that shifts in a configuration word and commits it atomically
// on chip-select release, while shifting out the previous word on MISO.
module spi_cfg_ctrl
    import spi_cfg_pkg::*;
#(
    parameter int N  = 18,
    parameter int K  = 4,
    parameter int L  = 2,
    parameter int D  = 5,
    parameter int DW = N + K + L + D + 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_clk,
    input  logic          spi_csn,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic [DW-1:0] cfg_word,
    output logic          cfg_update,
    output logic          frame_err,
    output logic [7:0]    err_cnt
);

    localparam logic [DW-1:0] CFG_DEF  = DW'(cfg_default());
    localparam logic [5:0]    CNT_FULL = 6'(DW);
    localparam logic [5:0]    CNT_SAT  = 6'(DW + 1);

    state_t          state, state_nx;
    logic            sck_rise, sck_fall, csn_rise, csn_fall;
    logic            mosi_s1, mosi_s2;
    logic [5:0]      bit_cnt;
    logic [DW-1:0]   wr_shift, rd_shift;

    sync_edge u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_clk),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge u_sync_csn (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_csn),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A frame with no clocks at all is treated as a harmless chip-select blip.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (csn_fall) state_nx = SHIFT;
            SHIFT: begin
                if (csn_rise) begin
                    if (bit_cnt == CNT_FULL)  state_nx = COMMIT;
                    else if (bit_cnt == '0)   state_nx = IDLE;
                    else                      state_nx = ABORT;
                end
            end
            COMMIT: state_nx = IDLE;
            ABORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            wr_shift   <= '0;
            rd_shift   <= '0;
            cfg_word   <= CFG_DEF;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            cfg_update <= (state == COMMIT);
            frame_err  <= (state == ABORT);
            if (state == COMMIT) begin
                cfg_word <= wr_shift;
            end
            if (state == ABORT && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (state == IDLE && csn_fall) begin
                bit_cnt  <= '0;
                rd_shift <= cfg_word;
            end
            // Chip-select release wins over a coincident spi_clk edge.
            if (state == SHIFT && !csn_rise) begin
                if (sck_rise) begin
                    wr_shift <= {wr_shift[DW-2:0], mosi_s2};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                if (sck_fall) begin
                    rd_shift <= {rd_shift[DW-2:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso = rd_shift[DW-1];

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Directed self-checking bench for spi_cfg_ctrl: SPI frames driven at clk/8
// with hand-computed expected configuration words and counters.
module tb_spi_cfg_ctrl;

    localparam logic [35:0] CFG_DEF = 36'h0_5F30_CCCD;
    localparam logic [35:0] WORD_A  = 36'h8_0001_0000;
    localparam logic [35:0] WORD_B  = 36'hA_5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [35:0] cfg_word;
    logic        cfg_update;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int upd_cnt = 0;
    int err_pulse_cnt = 0;

    spi_cfg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_csn    (spi_csn),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .cfg_word   (cfg_word),
        .cfg_update (cfg_update),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_update) upd_cnt++;
        if (frame_err) err_pulse_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csn_low();
        spi_csn = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_clk(4);
        m = spi_miso;
        spi_clk = 1'b1;
        wait_clk(4);
        spi_clk = 1'b0;
    endtask

    task automatic csn_high(output int lat);
        wait_clk(4);
        spi_csn = 1'b1;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            wait_clk(1);
            if (lat < 0 && (cfg_update || frame_err)) lat = i;
        end
    endtask

    task automatic spi_frame(input logic [63:0] data, input int nbits,
                             output logic [63:0] rd, output int lat);
        logic m;
        rd = '0;
        csn_low();
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit(data[i], m);
            rd[i] = m;
        end
        csn_high(lat);
    endtask

    task automatic test_reset();
        tests_run++;
        if (cfg_word !== CFG_DEF) begin
            tests_failed++;
            $display("[TB] FAIL reset_cfg_word got %h expected %h", cfg_word, CFG_DEF);
        end
        tests_run++;
        if (err_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_err_cnt got %0d expected 0", err_cnt);
        end
        tests_run++;
        if (spi_miso !== 1'b0 || cfg_update !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs got miso=%b upd=%b err=%b expected 0 0 0",
                     spi_miso, cfg_update, frame_err);
        end
    endtask

    task automatic test_commit(input logic [35:0] new_word, input logic [35:0] old_word,
                               input string tag);
        logic [63:0] rd;
        int lat, u0, e0;
        u0 = upd_cnt;
        e0 = err_pulse_cnt;
        spi_frame({28'd0, new_word}, 36, rd, lat);
        tests_run++;
        if (upd_cnt - u0 !== 1 || err_pulse_cnt - e0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_pulses got upd=%0d err=%0d expected 1 0",
                     tag, upd_cnt - u0, err_pulse_cnt - e0);
        end
        tests_run++;
        if (cfg_word !== new_word) begin
            tests_failed++;
            $display("[TB] FAIL %s_cfg_word got %h expected %h", tag, cfg_word, new_word);
        end
        tests_run++;
        if (rd[35:0] !== old_word) begin
            tests_failed++;
            $display("[TB] FAIL %s_miso got %h expected %h", tag, rd[35:0], old_word);
        end
        tests_run++;
        if (lat < 1 || lat > 5) begin
            tests_failed++;
            $display("[TB] FAIL %s_latency got %0d expected 1..5", tag, lat);
        end
    endtask

    task automatic test_bad_length(input int nbits, input logic [7:0] exp_cnt,
                                   input logic [35:0] exp_word);
        logic [63:0] rd;
        int lat, u0, e0;
        u0 = upd_cnt;
        e0 = err_pulse_cnt;
        spi_frame(64'h0_0000_0000_0001_2345, nbits, rd, lat);
        tests_run++;
        if (err_pulse_cnt - e0 !== 1 || upd_cnt - u0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bad%0d_pulses got err=%0d upd=%0d expected 1 0",
                     nbits, err_pulse_cnt - e0, upd_cnt - u0);
        end
        tests_run++;
        if (err_cnt !== exp_cnt) begin
            tests_failed++;
            $display("[TB] FAIL bad%0d_err_cnt got %0d expected %0d", nbits, err_cnt, exp_cnt);
        end
        tests_run++;
        if (cfg_word !== exp_word) begin
            tests_failed++;
            $display("[TB] FAIL bad%0d_cfg_word got %h expected %h", nbits, cfg_word, exp_word);
        end
        tests_run++;
        if (lat < 1 || lat > 5) begin
            tests_failed++;
            $display("[TB] FAIL bad%0d_latency got %0d expected 1..5", nbits, lat);
        end
    endtask

    task automatic test_empty_frame(input logic [7:0] exp_cnt);
        int lat, u0, e0;
        u0 = upd_cnt;
        e0 = err_pulse_cnt;
        csn_low();
        csn_high(lat);
        tests_run++;
        if (upd_cnt - u0 !== 0 || err_pulse_cnt - e0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL empty_pulses got upd=%0d err=%0d expected 0 0",
                     upd_cnt - u0, err_pulse_cnt - e0);
        end
        tests_run++;
        if (err_cnt !== exp_cnt) begin
            tests_failed++;
            $display("[TB] FAIL empty_err_cnt got %0d expected %0d", err_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        logic m;
        int lat, u0, e0;
        csn_low();
        for (int i = 0; i < 10; i++) send_bit(i[0], m);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (cfg_word !== CFG_DEF || err_cnt !== 8'd0 || spi_miso !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async got word=%h cnt=%0d miso=%b expected %h 0 0",
                     cfg_word, err_cnt, spi_miso, CFG_DEF);
        end
        wait_clk(2);
        rst_n = 1'b1;
        u0 = upd_cnt;
        e0 = err_pulse_cnt;
        for (int i = 0; i < 26; i++) send_bit(1'b1, m);
        csn_high(lat);
        tests_run++;
        if (upd_cnt - u0 !== 0 || err_pulse_cnt - e0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pulses got upd=%0d err=%0d expected 0 0",
                     upd_cnt - u0, err_pulse_cnt - e0);
        end
        tests_run++;
        if (cfg_word !== CFG_DEF || err_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_state got word=%h cnt=%0d expected %h 0",
                     cfg_word, err_cnt, CFG_DEF);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] rd;
        int lat, e0;
        e0 = err_pulse_cnt;
        for (int f = 0; f < 300; f++) begin
            spi_frame(64'd1, 1, rd, lat);
            if (f == 254) begin
                tests_run++;
                if (err_cnt !== 8'd255) begin
                    tests_failed++;
                    $display("[TB] FAIL sat_at_255 got %0d expected 255", err_cnt);
                end
            end
        end
        tests_run++;
        if (err_cnt !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL sat_final got %0d expected 255", err_cnt);
        end
        tests_run++;
        if (err_pulse_cnt - e0 !== 300) begin
            tests_failed++;
            $display("[TB] FAIL sat_pulses got %0d expected 300", err_pulse_cnt - e0);
        end
        tests_run++;
        if (cfg_word !== CFG_DEF) begin
            tests_failed++;
            $display("[TB] FAIL sat_cfg_word got %h expected %h", cfg_word, CFG_DEF);
        end
    endtask

    initial begin
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        test_reset();
        test_commit(WORD_A, CFG_DEF, "commit");
        test_commit(WORD_B, WORD_A, "back_to_back");
        test_bad_length(20, 8'd1, WORD_B);
        test_bad_length(37, 8'd2, WORD_B);
        test_empty_frame(8'd2);
        test_reset_midframe();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
